// File: rtl/truth_table_sweeper.sv
// Drives a,b,c,d through all 16 combinations, holds each for HOLD_CYCLES, and samples f into truth_table.
// Optional macro SWEEP_GRAY_EN selects Gray-code vector order. The result port is named truth_table because "table" is a reserved word.
module truth_table_sweeper #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [4:0] HOLD_LAST = 5'(HOLD_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] idx;
  logic [4:0] hold;
  logic [3:0] vec;

  function automatic logic [3:0] vec_of(input logic [3:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  assign {a, b, c, d} = vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 4'd0;
      hold        <= 5'd0;
      vec         <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= 16'h0000;
      count       <= 5'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= SETTLE;
            idx         <= 4'd0;
            hold        <= 5'd0;
            truth_table <= 16'h0000;
            count       <= 5'd0;
            done        <= 1'b0;
            busy        <= 1'b1;
            vec         <= vec_of(4'd0);
          end
        end
        SETTLE: begin
          if (hold == HOLD_LAST) begin
            // vec already equals vec_of(idx), so it doubles as the table index
            truth_table[vec] <= f;
            count            <= count + 5'd1;
            if (idx == 4'd15) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              vec   <= 4'd0;
            end else begin
              idx  <= idx + 4'd1;
              hold <= 5'd0;
              vec  <= vec_of(idx + 4'd1);
            end
          end else begin
            hold <= hold + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: unit 0 runs with HOLD_CYCLES=2, unit 1 with HOLD_CYCLES=1.
module tb_truth_table_sweeper;

  typedef struct {
    int          unit;
    int          s_cyc;
    int          done_cyc;
    logic [15:0] tbl;
    logic [4:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [2];
  logic        f_v     [2];
  logic        a_v     [2];
  logic        b_v     [2];
  logic        c_v     [2];
  logic        d_v     [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic [15:0] tbl_v   [2];
  logic [4:0]  cnt_v   [2];
  int          mode_v  [2];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  logic [3:0] gray_list [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  truth_table_sweeper #(.HOLD_CYCLES(2)) u_dut_h2 (
    .clk(clk), .rst(rst), .start(start_v[0]), .f(f_v[0]),
    .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .d(d_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .truth_table(tbl_v[0]), .count(cnt_v[0])
  );

  truth_table_sweeper #(.HOLD_CYCLES(1)) u_dut_h1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .f(f_v[1]),
    .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .d(d_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .truth_table(tbl_v[1]), .count(cnt_v[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Function under test: 0 a&b, 1 c^d, 2 const 0, 3 const 1
  function automatic logic fut(input int m, input logic a, input logic b, input logic c, input logic d);
    case (m)
      0:       return a & b;
      1:       return c ^ d;
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign f_v[0] = fut(mode_v[0], a_v[0], b_v[0], c_v[0], d_v[0]);
  assign f_v[1] = fut(mode_v[1], a_v[1], b_v[1], c_v[1], d_v[1]);

  function automatic logic [3:0] exp_vec(input int k);
    logic [3:0] kk;
    kk = 4'(k);
`ifdef SWEEP_GRAY_EN
    return gray_list[kk];
`else
    return kk;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: per-cycle vector/exclusivity checks, and result comparison when done appears
  always @(negedge clk) begin
    if (!rst && sbq.size() > 0) begin
      int u, h, k;
      u = sbq[0].unit;
      h = (u == 0) ? 2 : 1;
      k = (cyc - sbq[0].s_cyc) / h;
      chk("busy_done_exclusive", {31'd0, busy_v[u] & done_v[u]}, 32'd0);
      if (busy_v[u] && k < 16)
        chk("abcd_vector", {28'd0, a_v[u], b_v[u], c_v[u], d_v[u]}, {28'd0, exp_vec(k)});
      if (done_v[u]) begin
        chk("done_cycle", cyc, sbq[0].done_cyc);
        chk("table", {16'd0, tbl_v[u]}, {16'd0, sbq[0].tbl});
        chk("count", {27'd0, cnt_v[u]}, {27'd0, sbq[0].cnt});
        chk("abcd_idle", {28'd0, a_v[u], b_v[u], c_v[u], d_v[u]}, 32'd0);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic do_sweep(input int u, input logic [15:0] et);
    exp_t e;
    int h;
    h = (u == 0) ? 2 : 1;
    @(negedge clk);
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    start_v[u] = 1'b0;
    e.unit = u;
    e.s_cyc = cyc;
    e.done_cyc = cyc + 16 * h;
    e.tbl = et;
    e.cnt = 5'd16;
    sbq.push_back(e);
    chk("start_busy", {31'd0, busy_v[u]}, 32'd1);
    chk("start_done_low", {31'd0, done_v[u]}, 32'd0);
    chk("start_count_clear", {27'd0, cnt_v[u]}, 32'd0);
    chk("start_table_clear", {16'd0, tbl_v[u]}, 32'd0);
  endtask

  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL sweep_timeout actual=pending required=complete at cycle %0d", cyc);
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    mode_v[0] = 0;     mode_v[1] = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("rst_done", {31'd0, done_v[0]}, 32'd0);
    chk("rst_table", {16'd0, tbl_v[0]}, 32'd0);
    chk("rst_count", {27'd0, cnt_v[0]}, 32'd0);
    chk("rst_abcd", {28'd0, a_v[0], b_v[0], c_v[0], d_v[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // a&b with H=2
    mode_v[0] = 0;
    do_sweep(0, 16'hF000);
    wait_empty(60);

    // c^d with H=1
    mode_v[1] = 1;
    do_sweep(1, 16'h6666);
    wait_empty(40);

    // back-to-back: const 0 then const 1, second start while done
    mode_v[0] = 2;
    do_sweep(0, 16'h0000);
    wait_empty(60);
    repeat (2) @(posedge clk);
    #1;
    chk("done_held", {31'd0, done_v[0]}, 32'd1);
    chk("count_held", {27'd0, cnt_v[0]}, 32'd16);
    mode_v[0] = 3;
    do_sweep(0, 16'hFFFF);
    wait_empty(60);

    // asynchronous reset at vector 7
    mode_v[0] = 0;
    do_sweep(0, 16'hF000);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    sbq.delete();
    chk("midrst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("midrst_done", {31'd0, done_v[0]}, 32'd0);
    chk("midrst_count", {27'd0, cnt_v[0]}, 32'd0);
    chk("midrst_table", {16'd0, tbl_v[0]}, 32'd0);
    chk("midrst_abcd", {28'd0, a_v[0], b_v[0], c_v[0], d_v[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_sweep(0, 16'hF000);
    wait_empty(60);

    // start pulses during SETTLE must not restart the sweep
    mode_v[0] = 1;
    do_sweep(0, 16'h6666);
    for (int p = 0; p < 5; p++) begin
      repeat (3) @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    wait_empty(60);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that drives the four 1-bit inputs a, b, c, d of a 4-input combinational function block through all 16 input combinations. It holds each vector for a programmable settle time, samples the block's output f, and assembles a 16-bit truth table. It sits directly upstream of the function under test, which it feeds, and directly downstream of its output f, which it consumes. It replaces hand-written per-vector stimulus with one start pulse and one result word.

## Interface
- HOLD_CYCLES, default 2: cycles each vector is held before f is sampled; legal range 1..16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE or DONE.
- f  input  1  output of the function under test.
- a, b, c, d  output  1 each  vector driven to the function under test; a is MSB of the vector index.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next start or reset.
- table  output  16  result; bit k = f sampled while {a,b,c,d} = k.
- count  output  5  number of vectors sampled in the current or last sweep, 0..16.

## Operation
- Reset values: state IDLE, {a,b,c,d}=0000, busy=0, done=0, table=16'h0000, count=0, idx=0, hold=0.
- States: IDLE, SETTLE, DONE.
- IDLE or DONE with start=1: go to SETTLE; idx=0; hold=0; table=0; count=0; done=0; busy=1; drive vec(0).
- SETTLE: hold increments each cycle.
  - When hold == HOLD_CYCLES-1 at a clock edge, write f into table[code(idx)] and increment count.
  - If idx==15, go to DONE. Otherwise, increment idx, reset hold to 0, and drive vec(idx+1).
- DONE: busy=0; done=1; {a,b,c,d}=0000; table and count hold their values.
- start while in SETTLE is ignored; the sweep is not restarted.
- The vector index is 4 bits. idx never wraps inside a sweep; the transition at idx 15 goes to DONE.
- Binary order: vec(i)=i and code(i)=i.
- Asynchronous reset asserted mid-sweep: all registers return immediately to their reset values. No partial table is retained.

## Timing
- Name the clock edges E0, E1, …, with the start pulse sampled at E0.
- After E0: busy=1, {a,b,c,d}=vec(0).
- Vector i is driven from E(i·H) to E((i+1)·H), where H = HOLD_CYCLES.
- f is sampled at edge E((i+1)·H), so f sees exactly H full cycles of settle time.
- After E(16·H): busy=0, done=1, count=16, outputs 0000, table final.
- Each table bit and count update becomes visible in the cycle following its sampling edge.
- busy and done are never high together.
- With H=1, a new vector is driven every cycle. The sweep lasts 16 cycles.

## Configuration
- SWEEP_GRAY_EN defined: vectors are driven in 4-bit Gray order, vec(i) = i ^ (i>>1), i.e. 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8.
  - Exactly one input toggles between consecutive vectors.
  - The table is still indexed by vector value: code(i) = vec(i).
  - The final table is therefore identical to the binary-order result.
- SWEEP_GRAY_EN undefined: binary order 0..15.
- Timing and count are identical in both builds.

## Test plan
- f = a & b, H=2, start pulse → busy for 32 cycles; then done=1, table=16'hF000, count=16.
- f = c ^ d, H=1 → sweep completes 16 cycles after start; table=16'h6666; abcd changes every cycle.
- f tied to 0 and then to 1, two back-to-back sweeps, where the second start is issued while done=1 → table=16'h0000, then 16'hFFFF. count restarts from 0 and done drops for the duration of the second sweep.
- Reset asserted asynchronously at vector 7 of a sweep → busy, done, count and table are 0 at once. A following start produces the full correct table.
- start pulsed repeatedly during SETTLE → no restart. Completion edge is unchanged at E(16·H).
- SWEEP_GRAY_EN build, f = a & b → observed abcd sequence matches the Gray list; table=16'hF000.
